sobel_window_ctrl: RTL and testbench

Sequencer for the Sobel gradient datapath. Walks a 3-row by 4-pixel window across an image in byte-addressed pixel memory. Fetches each window's three row words into the 12-byte `data_buffer` shared by the gx/gy window blocks, pulses `enable_calc`, then flags when their registered gradient outputs are valid for downstream magnitude/threshold logic. Each window yields two output pixels: window 1 covers columns 0–2 and window 2 covers columns 1–3.

---
 rtl/sobel_window_ctrl.sv | 127 ++++++++++++
 tb/tb_sobel_window_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl.sv
// Sobel window sequencer: fetches 3 row words per 4-pixel window, triggers the
// gradient blocks, flags valid results. Optional macro SOBEL_CTRL_BACKPRESSURE_EN holds EMIT until out_ready.
module sobel_window_ctrl #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int AW    = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  output logic              mem_rd,
  output logic [AW-1:0]     mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [11:0][7:0]  data_buffer,
  output logic              enable_calc,
  output logic              result_valid,
  input  logic              out_ready,
  output logic [15:0]       pix_x,
  output logic [15:0]       pix_y,
  output logic              busy,
  output logic              done
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCHr | reading image row (row+r) into data_buffer bytes 4r..4r+3
  // CALC   | gradient blocks compute on a stable buffer
  // EMIT   | gradient outputs valid for both windows
  // DONE   | one-cycle end-of-frame pulse
  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, FETCH2, CALC, EMIT, DONE} state_t;

  localparam logic [15:0] COL_LAST = 16'(IMG_W - 4);
  localparam logic [15:0] ROW_LAST = 16'(IMG_H - 3);

  state_t          state, state_nxt;
  logic [AW-1:0]   base;
  logic [15:0]     col, row;
  logic [1:0]      fetch_r;
  logic            is_fetch;
  logic            emit_adv;
  logic            last_window;

`ifdef SOBEL_CTRL_BACKPRESSURE_EN
  assign emit_adv = out_ready;
`else
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign emit_adv = 1'b1;
`endif

  assign last_window = (col >= COL_LAST) && (row >= ROW_LAST);

  always_comb begin
    is_fetch = 1'b0;
    fetch_r  = 2'd0;
    case (state)
      FETCH0: is_fetch = 1'b1;
      FETCH1: begin is_fetch = 1'b1; fetch_r = 2'd1; end
      FETCH2: begin is_fetch = 1'b1; fetch_r = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH0;
      FETCH0:  if (mem_ack) state_nxt = FETCH1;
      FETCH1:  if (mem_ack) state_nxt = FETCH2;
      FETCH2:  if (mem_ack) state_nxt = CALC;
      CALC:    state_nxt = EMIT;
      EMIT:    if (emit_adv) state_nxt = last_window ? DONE : FETCH0;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      base        <= '0;
      col         <= '0;
      row         <= '0;
      data_buffer <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        base <= base_addr;
        col  <= '0;
        row  <= '0;
      end
      if (is_fetch && mem_ack) begin
        for (int k = 0; k < 4; k++)
          data_buffer[{fetch_r, 2'(k)}] <= mem_rdata[8*k +: 8];
      end
      if (state == EMIT && emit_adv) begin
        if (col < COL_LAST) begin
          col <= col + 16'd2;
        end else if (row < ROW_LAST) begin
          col <= '0;
          row <= row + 16'd1;
        end
      end
    end
  end

  // Outputs decode registered state/counters only; mem_ack never reaches an output.
  always_comb begin
    mem_rd       = is_fetch;
    mem_addr     = '0;
    enable_calc  = (state == CALC);
    result_valid = (state == EMIT);
    pix_x        = '0;
    pix_y        = '0;
    busy         = (state != IDLE);
    done         = (state == DONE);
    if (is_fetch)
      mem_addr = base + AW'((32'(row) + 32'(fetch_r)) * 32'(IMG_W) + 32'(col));
    if (state == EMIT) begin
      pix_x = col + 16'd1;
      pix_y = row + 16'd1;
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on an 8x4 ramp image with a simple byte memory responder.
module tb_sobel_window_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int AW    = 16;

`ifdef SOBEL_CTRL_BACKPRESSURE_EN
  localparam logic OR_IDLE = 1'b1;
  localparam int   HOLD_EXP = 5;
`else
  localparam logic OR_IDLE = 1'b0;
  localparam int   HOLD_EXP = 1;
`endif

  logic             clk = 0;
  logic             n_rst = 0;
  logic             start = 0;
  logic [AW-1:0]    base_addr = '0;
  logic             mem_rd;
  logic [AW-1:0]    mem_addr;
  logic [31:0]      mem_rdata;
  logic             mem_ack;
  logic [11:0][7:0] data_buffer;
  logic             enable_calc, result_valid, busy, done;
  logic             out_ready = 0;
  logic [15:0]      pix_x, pix_y;

  sobel_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .base_addr(base_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .data_buffer(data_buffer), .enable_calc(enable_calc), .result_valid(result_valid),
    .out_ready(out_ready), .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // byte memory with programmable ack latency
  logic [7:0] mem [0:1023];
  int         ack_delay = 0;
  int         wait_cnt = 0;
  logic       stray_ack = 0;
  logic [9:0] a10;
  assign a10       = mem_addr[9:0];
  assign mem_rdata = {mem[a10 + 10'd3], mem[a10 + 10'd2], mem[a10 + 10'd1], mem[a10]};
  assign mem_ack   = stray_ack | (mem_rd && (wait_cnt >= ack_delay));

  always @(posedge clk) begin
    if (mem_rd && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int pb(input int r, input int c);
    return int'(data_buffer[4*r + c]);
  endfunction

  function automatic int gx(input int c0);
    return (pb(0, c0+2) - pb(0, c0)) + 2*(pb(1, c0+2) - pb(1, c0)) + (pb(2, c0+2) - pb(2, c0));
  endfunction

  // monitor
  logic mon_en = 0;
  int   cyc = 0, first_cyc = 0, done_cyc = 0, last_valid_cyc = 0, done_cnt = 0;
  logic busy_q = 0;
  int   res_px[$], res_py[$], res_gx1[$], res_gx2[$], addr_q[$];

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (busy && !busy_q) first_cyc = cyc;
      if (mem_rd && mem_ack) addr_q.push_back(int'(mem_addr));
      if (result_valid) begin
        res_px.push_back(int'(pix_x));
        res_py.push_back(int'(pix_y));
        res_gx1.push_back(gx(0));
        res_gx2.push_back(gx(1));
        last_valid_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
    end
    busy_q = busy;
  end

  typedef struct {
    int px;
    int py;
    int a0;
    int a1;
    int a2;
  } win_t;
  win_t tbl[6];

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_buf_any"}, |data_buffer, 0);
    check({tag, "_enable_calc"}, enable_calc, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pix"}, {pix_x, pix_y}, 0);
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    base_addr = base;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    base_addr = 16'h0BAD;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    check({tag, "_done_seen"}, seen, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input bit busy_start);
    bit seen = 0;
    res_px.delete(); res_py.delete(); res_gx1.delete(); res_gx2.delete(); addr_q.delete();
    done_cnt = 0;
    mon_en = 1;
    pulse_start(16'h0100);
    for (int i = 0; i < 300; i++) begin
      if (busy_start && i == 7) begin base_addr = 16'h0200; start = 1; end
      if (busy_start && i == 8) begin start = 0; base_addr = 16'h0BAD; end
      @(posedge clk);
      #1;
      if (done_cnt != 0) begin seen = 1; break; end
    end
    mon_en = 0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_n_results"}, res_px.size(), 6);
    check({tag, "_n_fetches"}, addr_q.size(), 18);
    for (int i = 0; i < 6; i++) begin
      if (i < res_px.size()) begin
        check($sformatf("%s_w%0d_pix", tag, i), {res_px[i], res_py[i]}, {tbl[i].px, tbl[i].py});
        check($sformatf("%s_w%0d_gx1", tag, i), res_gx1[i], 8);
        check($sformatf("%s_w%0d_gx2", tag, i), res_gx2[i], 8);
      end
      if (3*i + 2 < addr_q.size())
        check($sformatf("%s_w%0d_addr", tag, i), {addr_q[3*i], addr_q[3*i+1], addr_q[3*i+2]},
              {tbl[i].a0, tbl[i].a1, tbl[i].a2});
    end
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_start_to_done"}, done_cyc - first_cyc, 30);
    check({tag, "_done_after_last"}, done_cyc - last_valid_cyc, 1);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int cnt;
    bit seen;
    tbl[0] = '{1, 1, 'h100, 'h108, 'h110};
    tbl[1] = '{3, 1, 'h102, 'h10A, 'h112};
    tbl[2] = '{5, 1, 'h104, 'h10C, 'h114};
    tbl[3] = '{1, 2, 'h108, 'h110, 'h118};
    tbl[4] = '{3, 2, 'h10A, 'h112, 'h11A};
    tbl[5] = '{5, 2, 'h10C, 'h114, 'h11C};
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a % 8);
    out_ready = OR_IDLE;

    // reset state
    #2;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 n_rst = 1;
    @(posedge clk);
    #1;

    run_frame("frame_a", 0);

    // delayed ack: address held, no calc until all rows in
    ack_delay = 3;
    mem[16'h108] = 8'h01; mem[16'h109] = 8'h02; mem[16'h10A] = 8'h03; mem[16'h10B] = 8'h04;
    pulse_start(16'h0100);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check($sformatf("delay_r%0d_k%0d", r, k), {mem_rd, enable_calc, mem_addr},
              {1'b1, 1'b0, 16'(16'h0100 + 8*r)});
      end
    end
    @(negedge clk);
    check("delay_calc", enable_calc, 1);
    check("delay_row1_bytes", data_buffer[7:4], 32'h04030201);
    wait_done("delay_frame");
    for (int a = 16'h108; a < 16'h10C; a++) mem[a] = 8'(a % 8);

    // reset mid-FETCH2
    pulse_start(16'h0100);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 16'h0110) begin seen = 1; break; end
    end
    check("rst_reached_fetch2", seen, 1);
    check("rst_buf_loaded", |data_buffer, 1);
    n_rst = 0;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk);
    #1 n_rst = 1;
    ack_delay = 0;
    stray_ack = 1;
    @(negedge clk);
    check("stray_busy", busy, 0);
    check("stray_buf", |data_buffer, 0);
    @(posedge clk);
    #1 stray_ack = 0;
    @(posedge clk);
    #1;
    run_frame("frame_b", 0);

    // start while busy is ignored
    run_frame("frame_c", 1);

    // out_ready low for the first 4 EMIT cycles
    out_ready = 0;
    pulse_start(16'h0100);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (result_valid) begin seen = 1; break; end
    end
    check("bp_first_valid", seen, 1);
    check("bp_first_pix", {pix_x, pix_y}, {16'd1, 16'd1});
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      if (cnt == 4) begin
        @(posedge clk);
        #1 out_ready = 1;
      end
      @(negedge clk);
      if (!result_valid) break;
      cnt++;
      check($sformatf("bp_hold%0d", cnt), {mem_rd, enable_calc, pix_x, pix_y}, {2'b00, 16'd1, 16'd1});
    end
    check("bp_valid_cycles", cnt, HOLD_EXP);
    out_ready = 1;
    wait_done("bp_frame");
    out_ready = OR_IDLE;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
